// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
//   Parallel-in, serial-out frame transmitter. Takes one WIDTH-bit word over a
//   valid/ready handshake and sends it on a single wire as
//     start bit (0), WIDTH data bits LSB first, stop bit (1),
//   with every bit held for CLKS_PER_BIT clocks. The line idles high.
//
// Parameters
//   WIDTH         data bits per frame (>= 1)
//   CLKS_PER_BIT  clocks each serial bit is held (>= 1)
//
// Ports
//   clk        system clock, all state changes on posedge
//   rst_n      asynchronous active-low reset; aborts any frame in flight
//   din        word to transmit, sampled only on an accepting edge
//   din_valid  source presents a word on din
//   din_ready  registered; high while the transmitter is idle
//   sout       serial line output (registered)
//   busy       high while a frame (start, data or stop) is in progress
//   done       one-cycle pulse on the edge that returns to idle
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH) + 1;
  localparam int DIV_W = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BIT_W-1:0] bitcnt;
  logic [DIV_W-1:0] divcnt;
  logic             bit_end;
  logic             accept;

  // The next data bit is taken from the already-shifted word so that sout
  // stays a pure register output and WIDTH=1 needs no special case.
  assign shreg_nxt = shreg >> 1;
  assign bit_end   = (divcnt == DIV_LAST);
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      divcnt    <= '0;
      sout      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          divcnt <= '0;
          bitcnt <= '0;
          if (accept) begin
            shreg     <= din;
            state     <= ST_START;
            sout      <= 1'b0;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end else begin
            // Also the path that first raises din_ready after reset release;
            // din_ready was still 0 on that edge, so nothing is accepted.
            sout      <= 1'b1;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end) begin
            divcnt <= '0;
            bitcnt <= '0;
            state  <= ST_DATA;
            sout   <= shreg[0];
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            divcnt <= '0;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt + BIT_W'(1);
            if (bitcnt == BIT_LAST) begin
              state <= ST_STOP;
              sout  <= 1'b1;
            end else begin
              sout <= shreg_nxt[0];
            end
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            divcnt    <= '0;
            state     <= ST_IDLE;
            sout      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            din_ready <= 1'b1;
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          sout      <= 1'b1;
          busy      <= 1'b0;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx
//   Directed bench for serial_tx. dut1 runs at one clock per bit, dut4 at four
//   clocks per bit. A capture model on dut1 reassembles every completed frame
//   and checks it against words queued when they were offered.
// ---------------------------------------------------------------------------
module tb_serial_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [W-1:0] din1 = '0;
  logic         din_valid1 = 1'b0;
  logic         din_ready1, sout1, busy1, done1;

  logic [W-1:0] din4 = '0;
  logic         din_valid4 = 1'b0;
  logic         din_ready4, sout4, busy4, done4;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] sb1[$];
  logic [W+1:0] cap1 = '0;
  int           cnt1 = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .sout(sout1), .busy(busy1), .done(done1)
  );

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din_valid4),
    .din_ready(din_ready4), .sout(sout4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(input string tag, input int max);
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, done1, 1'b1);
  endtask

  // Reference receiver: sample the line mid-cycle while busy, LSB first.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done1 === 1'b1) begin
      chk("frame_len", cnt1, W + 2);
      if (sb1.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb1.pop_front();
        chk("frame_bits", cap1, {1'b1, e, 1'b0});
      end
      cnt1 = 0;
    end else if (busy1 === 1'b1) begin
      cap1 = {sout1, cap1[W+1:1]};
      cnt1++;
    end else begin
      cnt1 = 0;
    end
  end

  initial begin
    logic [W+1:0] fr;
    int           n;

    // Reset held with a word on offer.
    din_valid1 = 1'b1;
    din1       = 8'h77;
    din_valid4 = 1'b1;
    tick();
    tick();
    chk("rst_sout", sout1, 1'b1);
    chk("rst_ready", din_ready1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_sout4", sout4, 1'b1);

    rst_n = 1'b1;
    tick();
    chk("rel_ready", din_ready1, 1'b1);
    chk("rel_nobusy", busy1, 1'b0);
    chk("rel_sout", sout1, 1'b1);
    chk("rel_ready4", din_ready4, 1'b1);
    din_valid1 = 1'b0;
    din_valid4 = 1'b0;
    tick();
    chk("rel_still_idle", busy1, 1'b0);

    // Single frame A5.
    din1       = 8'hA5;
    din_valid1 = 1'b1;
    sb1.push_back(8'hA5);
    tick();
    din_valid1 = 1'b0;
    din1       = 8'h00;
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < W + 2; k++) begin
      chk($sformatf("a5_sout%0d", k), sout1, fr[k]);
      chk($sformatf("a5_busy%0d", k), busy1, 1'b1);
      chk($sformatf("a5_ready%0d", k), din_ready1, 1'b0);
      tick();
    end
    chk("a5_done", done1, 1'b1);
    chk("a5_ready", din_ready1, 1'b1);
    chk("a5_busy_end", busy1, 1'b0);
    tick();
    chk("a5_done_pulse", done1, 1'b0);

    // Back-to-back with din_valid held.
    din1       = 8'h00;
    din_valid1 = 1'b1;
    sb1.push_back(8'h00);
    tick();
    din1 = 8'hFF;
    sb1.push_back(8'hFF);
    for (int k = 0; k < W + 2; k++) begin
      chk($sformatf("b2b_first%0d", k), sout1, (k == W + 1) ? 1'b1 : 1'b0);
      tick();
    end
    chk("b2b_gap_sout", sout1, 1'b1);
    chk("b2b_gap_busy", busy1, 1'b0);
    chk("b2b_gap_ready", din_ready1, 1'b1);
    tick();
    chk("b2b_second_accept", busy1, 1'b1);
    chk("b2b_second_start", sout1, 1'b0);
    din_valid1 = 1'b0;
    for (int k = 1; k < W + 1; k++) begin
      tick();
      chk($sformatf("b2b_second%0d", k), sout1, 1'b1);
    end
    wait_done1("b2b_done_timeout", 4);
    tick();

    // Divider: CLKS_PER_BIT=4, word 01.
    din4       = 8'h01;
    din_valid4 = 1'b1;
    chk("div_ready", din_ready4, 1'b1);
    tick();
    din_valid4 = 1'b0;
    fr = {1'b1, 8'h01, 1'b0};
    for (int k = 0; k < 4 * (W + 2); k++) begin
      chk($sformatf("div_sout%0d", k), sout4, fr[k / 4]);
      if (k == 4 * (W + 2) - 1) chk("div_done_early", done4, 1'b0);
      tick();
    end
    chk("div_done", done4, 1'b1);
    chk("div_busy_end", busy4, 1'b0);
    chk("div_ready_end", din_ready4, 1'b1);
    tick();

    // din changed and din_valid pulsed mid-frame are ignored.
    din1       = 8'hC3;
    din_valid1 = 1'b1;
    sb1.push_back(8'hC3);
    tick();
    din_valid1 = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    din1       = 8'h3C;
    din_valid1 = 1'b1;
    tick();
    tick();
    din_valid1 = 1'b0;
    wait_done1("ign_done_timeout", 12);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ign_no_frame%0d", k), busy1, 1'b0);
    end
    chk("ign_sb_empty", sb1.size(), 0);

    // Asynchronous reset during data bit 3 of 96 (bit 3 is 0).
    din1       = 8'h96;
    din_valid1 = 1'b1;
    sb1.push_back(8'h96);
    tick();
    din_valid1 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_bit3", sout1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sout", sout1, 1'b1);
    chk("mid_rst_busy", busy1, 1'b0);
    chk("mid_rst_ready", din_ready1, 1'b0);
    sb1.delete();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", din_ready1, 1'b1);
    din1       = 8'h5A;
    din_valid1 = 1'b1;
    sb1.push_back(8'h5A);
    tick();
    din_valid1 = 1'b0;
    chk("mid_new_busy", busy1, 1'b1);
    wait_done1("mid_done_timeout", 12);
    tick();
    chk("end_sb_empty", sb1.size(), 0);

    n = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
